// File: rtl/cbus_arbiter.sv
// Cache-bus arbiter: shares one cbus between the L1 caches with round-robin grants.
// A grant is held for the whole burst and released on the final accepted beat.
package cbus_pkg;
  typedef enum logic [3:0] {
    MLEN1   = 4'd0,
    MLEN2   = 4'd1,
    MLEN4   = 4'd2,
    MLEN8   = 4'd3,
    MLEN16  = 4'd4,
    MLEN32  = 4'd5,
    MLEN64  = 4'd6,
    MLEN128 = 4'd7,
    MLEN256 = 4'd8
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        write;
    cbus_len_t   len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;
endpackage

module cbus_arbiter
  import cbus_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  localparam int SEL_BITS = $clog2(NUM_INPUTS)
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  ireqs  [NUM_INPUTS],
  output cbus_resp_t iresps [NUM_INPUTS],
  output cbus_req_t  oreq,
  input  cbus_resp_t oresp
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam int unsigned NI_U = NUM_INPUTS;

  state_t              r_state;
  logic [SEL_BITS-1:0] r_owner;
  logic [SEL_BITS-1:0] r_ptr;

  state_t              w_state_nxt;
  logic [SEL_BITS-1:0] w_owner_nxt;
  logic [SEL_BITS-1:0] w_ptr_nxt;
  logic                w_found;
  logic [SEL_BITS-1:0] w_sel;

  // (base + off) mod NUM_INPUTS, valid for off < NUM_INPUTS
  function automatic logic [SEL_BITS-1:0] rr_index(input logic [SEL_BITS-1:0] base,
                                                   input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NI_U) sum = sum - NI_U;
    return sum[SEL_BITS-1:0];
  endfunction

  // Scan downwards so the candidate closest to ptr is the one left in w_sel.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (ireqs[rr_index(r_ptr, k)].valid) begin
        w_found = 1'b1;
        w_sel   = rr_index(r_ptr, k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt = BUSY;
          w_owner_nxt = w_sel;
        end
      end
      BUSY: begin
        if (oresp.ready && oresp.last) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = rr_index(r_owner, 1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // Nothing is forwarded in IDLE, so the arbitration cycle costs exactly one clock.
  always_comb begin
    oreq = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      iresps[i] = '0;
    end
    if (r_state == BUSY) begin
      oreq            = ireqs[r_owner];
      iresps[r_owner] = oresp;
    end
  end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed bench for cbus_arbiter: expected grant order is queued as requests are
// raised and popped when each grant shows up on oreq.
module tb_cbus_arbiter;
  import cbus_pkg::*;

  localparam logic [31:0] ADDR0 = 32'h1000_0040;
  localparam logic [31:0] ADDR1 = 32'h8000_0800;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  ireqs  [2];
  cbus_resp_t iresps [2];
  cbus_req_t  oreq;
  cbus_resp_t oresp;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  cbus_arbiter #(.NUM_INPUTS(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .ireqs  (ireqs),
    .iresps (iresps),
    .oreq   (oreq),
    .oresp  (oresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input cbus_len_t len);
    ireqs[p].valid = v;
    ireqs[p].write = 1'b0;
    ireqs[p].len   = len;
    ireqs[p].addr  = (p == 0) ? ADDR0 : ADDR1;
    ireqs[p].wdata = '0;
    ireqs[p].wstrb = '0;
  endtask

  task automatic idle_chk(input string tag);
    #1;
    chk({tag, "_oreq_valid"}, 64'(oreq.valid), 64'd0);
    chk({tag, "_oreq_addr"},  64'(oreq.addr),  64'd0);
    chk({tag, "_resp0"},      64'(iresps[0]),  64'd0);
    chk({tag, "_resp1"},      64'(iresps[1]),  64'd0);
    chk({tag, "_busy"},       64'(dut.r_state), 64'd0);
  endtask

  task automatic grant_chk(input string tag);
    int exp_p;
    int obs_p;
    chk({tag, "_valid"}, 64'(oreq.valid), 64'd1);
    obs_p = (oreq.addr == ADDR0) ? 0 : ((oreq.addr == ADDR1) ? 1 : 7);
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'd1);
    exp_p = (exp_q.size() > 0) ? exp_q.pop_front() : 9;
    chk({tag, "_port"}, 64'(obs_p), 64'(exp_p));
  endtask

  task automatic run_beats(input int p, input int first, input int count, input int tlen);
    for (int b = first; b < first + count; b++) begin
      oresp.ready = 1'b1;
      oresp.last  = (b == tlen - 1);
      oresp.rdata = $urandom;
      #1;
      chk("beat_resp_owner", 64'(iresps[p]), 64'(oresp));
      chk("beat_resp_other", 64'(iresps[1-p]), 64'd0);
      chk("beat_oreq_addr", 64'(oreq.addr), 64'((p == 0) ? ADDR0 : ADDR1));
      cyc();
    end
    oresp = '0;
  endtask

  initial begin
    reset = 1'b1;
    ireqs[0] = '0;
    ireqs[1] = '0;
    oresp = '0;
    cyc();
    cyc();
    idle_chk("reset");
    chk("reset_ptr", 64'(dut.r_ptr), 64'd0);
    reset = 1'b0;

    // single 256-beat fill from port 1
    set_req(1, 1'b1, MLEN256);
    exp_q.push_back(1);
    #1 chk("s1_no_forward_same_cycle", 64'(oreq.valid), 64'd0);
    cyc();
    grant_chk("s1_grant");
    chk("s1_owner", 64'(dut.r_owner), 64'd1);
    run_beats(1, 0, 256, 256);
    set_req(1, 1'b0, MLEN256);
    idle_chk("s1_release");
    chk("s1_ptr", 64'(dut.r_ptr), 64'd0);
    cyc();
    idle_chk("s1_stay_idle");

    // both valid while leaving reset
    reset = 1'b1;
    set_req(0, 1'b1, MLEN8);
    set_req(1, 1'b1, MLEN8);
    cyc();
    reset = 1'b0;
    idle_chk("s2_reset_override");
    exp_q.push_back(0);
    exp_q.push_back(1);
    cyc();
    grant_chk("s2_first");
    run_beats(0, 0, 8, 8);
    set_req(0, 1'b0, MLEN8);
    idle_chk("s2_gap");
    chk("s2_ptr_after_p0", 64'(dut.r_ptr), 64'd1);
    cyc();
    grant_chk("s2_second");
    run_beats(1, 0, 8, 8);
    set_req(1, 1'b0, MLEN8);
    idle_chk("s2_done");
    chk("s2_ptr_after_p1", 64'(dut.r_ptr), 64'd0);

    // back-to-back single-beat accesses alternate
    set_req(0, 1'b1, MLEN1);
    set_req(1, 1'b1, MLEN1);
    for (int i = 0; i < 4; i++) exp_q.push_back(i % 2);
    for (int i = 0; i < 4; i++) begin
      cyc();
      grant_chk("s3_alt");
      run_beats(i % 2, 0, 1, 1);
      idle_chk("s3_gap");
    end
    set_req(0, 1'b0, MLEN1);
    set_req(1, 1'b0, MLEN1);
    chk("s3_ptr", 64'(dut.r_ptr), 64'd0);
    cyc();
    idle_chk("s3_quiet");

    // port 0 arrives mid-burst and must wait for port 1's last beat
    set_req(1, 1'b1, MLEN256);
    exp_q.push_back(1);
    cyc();
    grant_chk("s4_grant1");
    run_beats(1, 0, 100, 256);
    set_req(0, 1'b1, MLEN4);
    exp_q.push_back(0);
    run_beats(1, 100, 156, 256);
    set_req(1, 1'b0, MLEN256);
    idle_chk("s4_gap");
    cyc();
    grant_chk("s4_grant0");
    run_beats(0, 0, 4, 4);
    set_req(0, 1'b0, MLEN4);
    idle_chk("s4_done");
    chk("s4_ptr", 64'(dut.r_ptr), 64'd1);

    // reset in the middle of a burst
    set_req(0, 1'b1, MLEN256);
    exp_q.push_back(0);
    cyc();
    grant_chk("s5_grant0");
    run_beats(0, 0, 50, 256);
    reset = 1'b1;
    set_req(0, 1'b0, MLEN256);
    set_req(1, 1'b1, MLEN2);
    cyc();
    idle_chk("s5_after_reset");
    chk("s5_ptr", 64'(dut.r_ptr), 64'd0);
    reset = 1'b0;
    exp_q.push_back(1);
    cyc();
    grant_chk("s5_grant1");
    run_beats(1, 0, 2, 2);
    set_req(1, 1'b0, MLEN2);
    idle_chk("s5_done");

    // spurious bridge handshake while idle
    oresp.ready = 1'b1;
    oresp.last  = 1'b1;
    oresp.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("s6_ready0", 64'(iresps[0].ready), 64'd0);
      chk("s6_ready1", 64'(iresps[1].ready), 64'd0);
      chk("s6_oreq_valid", 64'(oreq.valid), 64'd0);
      cyc();
      chk("s6_ptr", 64'(dut.r_ptr), 64'd0);
    end
    oresp = '0;

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
